// File: rtl/bp_looper_pkg.sv
// Shared definitions for the hardware looper device.
//   - Register offsets within the device window (low 20 address bits).
//   - Control register bit positions.
//   - Responder FSM state encoding.
//   - Response packet layout held between accept and consume.
package bp_looper_pkg;

    localparam logic [19:0] hw_looper_control_addr_gp    = 20'h0_0000;
    localparam logic [19:0] hw_looper_start_addr_gp      = 20'h0_0008;
    localparam logic [19:0] hw_looper_end_addr_gp        = 20'h0_0010;
    localparam logic [19:0] hw_looper_next_alloc_addr_gp = 20'h0_0018;
    localparam logic [19:0] hw_looper_size_addr_gp       = 20'h0_0020;

    localparam int looper_enable_bit_gp    = 0;
    localparam int looper_exhausted_bit_gp = 1;

    // Widest data path the response packet can carry.
    localparam int looper_pkt_data_width_gp = 64;

    typedef enum logic {
        e_ready = 1'b0,
        e_resp  = 1'b1
    } bp_looper_state_e;

    typedef struct packed {
        logic                                err;
        logic [looper_pkt_data_width_gp-1:0] data;
    } bp_looper_resp_s;

endpackage

// File: rtl/bp_looper_claim.sv
// Combinational claim datapath.
//   enable, cursor, limit, size : current looper state
//   grant       : a chunk is available (enable & cursor < limit)
//   claim_data  : value returned to the claiming core
//   cursor_next : cursor after the claim (saturates at limit)
module bp_looper_claim
    import bp_looper_pkg::*;
#(
    parameter int index_width_p = 32
) (
    input  logic                     enable,
    input  logic [index_width_p-1:0] cursor,
    input  logic [index_width_p-1:0] limit,
    input  logic [index_width_p-1:0] size,
    output logic                     grant,
    output logic [index_width_p-1:0] claim_data,
    output logic [index_width_p-1:0] cursor_next
);

    // One extra bit so a sum that wraps the index width still compares
    // as larger than limit and clamps instead of wrapping to a small value.
    logic [index_width_p:0] sum_wide;

    assign sum_wide    = {1'b0, cursor} + {1'b0, size};
    assign grant       = enable & (cursor < limit);
    assign claim_data  = grant ? cursor : limit;
    assign cursor_next = !grant                     ? cursor :
                         (sum_wide >= {1'b0, limit}) ? limit  :
                                                       sum_wide[index_width_p-1:0];

endmodule

// File: rtl/bp_looper_dev.sv
// Memory-mapped hardware looper responder (single outstanding command).
//   clk_i/reset_i            : clock, synchronous active-high reset
//   cmd_v_i/cmd_ready_o      : command handshake
//   cmd_w_i, cmd_addr_i, cmd_data_i : store flag, address, store data
//   resp_v_o/resp_yumi_i     : response handshake
//   resp_data_o, resp_err_o  : load data, unmapped/misaligned flag
//   active_o                 : enable & (cursor < end)
module bp_looper_dev
    import bp_looper_pkg::*;
#(
    parameter int paddr_width_p = 40,
    parameter int data_width_p  = 64,
    parameter int index_width_p = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cmd_v_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_w_i,
    input  logic [paddr_width_p-1:0] cmd_addr_i,
    input  logic [data_width_p-1:0]  cmd_data_i,
    output logic                     resp_v_o,
    input  logic                     resp_yumi_i,
    output logic [data_width_p-1:0]  resp_data_o,
    output logic                     resp_err_o,
    output logic                     active_o
);

    localparam int pad_width_lp = looper_pkt_data_width_gp - index_width_p;

    bp_looper_state_e         state_reg, state_next;
    logic                     enable_reg, enable_next;
    logic [index_width_p-1:0] start_reg, start_next;
    logic [index_width_p-1:0] end_reg, end_next;
    logic [index_width_p-1:0] cursor_reg, cursor_next;
    logic [index_width_p-1:0] size_reg, size_next;
    bp_looper_resp_s          resp_reg, resp_next;

    logic                     accept;
    logic [19:0]              offset;
    logic [index_width_p-1:0] wdata;
    logic                     grant;
    logic [index_width_p-1:0] claim_data, claim_cursor;
    logic                     unused_bits;

    // Device selection happens upstream; only the low window bits decode here.
    assign unused_bits = ^{cmd_addr_i, cmd_data_i};
    assign offset      = cmd_addr_i[19:0];
    assign wdata       = cmd_data_i[index_width_p-1:0];

    assign cmd_ready_o = (state_reg == e_ready) & ~reset_i;
    assign accept      = cmd_v_i & cmd_ready_o;
    assign resp_v_o    = (state_reg == e_resp);
    assign resp_data_o = resp_reg.data[data_width_p-1:0];
    assign resp_err_o  = resp_reg.err;
    assign active_o    = enable_reg & (cursor_reg < end_reg);

    bp_looper_claim #(.index_width_p(index_width_p)) claim (
        .enable      (enable_reg),
        .cursor      (cursor_reg),
        .limit       (end_reg),
        .size        (size_reg),
        .grant       (grant),
        .claim_data  (claim_data),
        .cursor_next (claim_cursor)
    );

    always_comb begin
        state_next  = state_reg;
        enable_next = enable_reg;
        start_next  = start_reg;
        end_next    = end_reg;
        cursor_next = cursor_reg;
        size_next   = size_reg;
        resp_next   = resp_reg;

        case (state_reg)
            e_ready: begin
                if (accept) begin
                    state_next = e_resp;
                    resp_next  = '0;
                    if (offset[2:0] != 3'b000) begin
                        resp_next.err = 1'b1;
                    end else if (cmd_w_i) begin
                        case (offset)
                            hw_looper_control_addr_gp: begin
                                enable_next = wdata[looper_enable_bit_gp];
                                // Enabling always re-arms, even if already on.
                                if (wdata[looper_enable_bit_gp]) cursor_next = start_reg;
                            end
                            hw_looper_start_addr_gp:      start_next  = wdata;
                            hw_looper_end_addr_gp:        end_next    = wdata;
                            hw_looper_next_alloc_addr_gp: cursor_next = wdata;
                            hw_looper_size_addr_gp:       size_next   = wdata;
                            default:                      resp_next.err = 1'b1;
                        endcase
                    end else begin
                        case (offset)
                            hw_looper_control_addr_gp: begin
                                resp_next.data[looper_enable_bit_gp]    = enable_reg;
                                resp_next.data[looper_exhausted_bit_gp] = enable_reg & ~(cursor_reg < end_reg);
                            end
                            hw_looper_start_addr_gp: resp_next.data = {{pad_width_lp{1'b0}}, start_reg};
                            hw_looper_end_addr_gp:   resp_next.data = {{pad_width_lp{1'b0}}, end_reg};
                            hw_looper_next_alloc_addr_gp: begin
                                resp_next.data = {{pad_width_lp{1'b0}}, claim_data};
                                cursor_next    = claim_cursor;
                            end
                            hw_looper_size_addr_gp:  resp_next.data = {{pad_width_lp{1'b0}}, size_reg};
                            default:                 resp_next.err  = 1'b1;
                        endcase
                    end
                end
            end
            e_resp: begin
                if (resp_yumi_i) state_next = e_ready;
            end
            default: state_next = e_ready;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg  <= e_ready;
            enable_reg <= 1'b0;
            start_reg  <= '0;
            end_reg    <= '0;
            cursor_reg <= '0;
            size_reg   <= '0;
            resp_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            enable_reg <= enable_next;
            start_reg  <= start_next;
            end_reg    <= end_next;
            cursor_reg <= cursor_next;
            size_reg   <= size_next;
            resp_reg   <= resp_next;
        end
    end

endmodule

// File: tb/tb_bp_looper_dev.sv
// Testbench for bp_looper_dev: table-driven directed vectors, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_bp_looper_dev;

    localparam logic [39:0] base_c = 40'h00_0050_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_v = 1'b0;
    logic        cmd_ready;
    logic        cmd_w = 1'b0;
    logic [39:0] cmd_addr = '0;
    logic [63:0] cmd_data = '0;
    logic        resp_v;
    logic        resp_yumi = 1'b0;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        active;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    bit              m_en;
    longint unsigned m_start, m_end, m_cur, m_size;

    always #5 clk = ~clk;

    bp_looper_dev dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .cmd_v_i     (cmd_v),
        .cmd_ready_o (cmd_ready),
        .cmd_w_i     (cmd_w),
        .cmd_addr_i  (cmd_addr),
        .cmd_data_i  (cmd_data),
        .resp_v_o    (resp_v),
        .resp_yumi_i (resp_yumi),
        .resp_data_o (resp_data),
        .resp_err_o  (resp_err),
        .active_o    (active)
    );

    typedef struct {
        logic        w;
        logic [39:0] addr;
        logic [63:0] data;
        logic [63:0] exp_data;
        logic        exp_err;
        logic        exp_active;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_en = 0; m_start = 0; m_end = 0; m_cur = 0; m_size = 0;
    endfunction

    function automatic void model_step(input logic w, input logic [39:0] a, input logic [63:0] d,
                                       output logic [63:0] ed, output logic ee);
        longint unsigned v = longint'(d[31:0]);
        ed = 0; ee = 0;
        case (a[19:0])
            20'h00: if (w) begin
                        m_en = d[0];
                        if (d[0]) m_cur = m_start;
                    end else begin
                        ed = {62'd0, (m_en && m_cur >= m_end), m_en};
                    end
            20'h08: if (w) m_start = v; else ed = m_start;
            20'h10: if (w) m_end = v;   else ed = m_end;
            20'h18: if (w) m_cur = v;
                    else if (m_en && m_cur < m_end) begin
                        ed = m_cur;
                        m_cur = (m_cur + m_size > m_end) ? m_end : m_cur + m_size;
                    end else begin
                        ed = m_end;
                    end
            20'h20: if (w) m_size = v;  else ed = m_size;
            default: ee = 1;
        endcase
    endfunction

    function automatic logic model_active();
        return m_en && (m_cur < m_end);
    endfunction

    // One complete command/response transaction with bounded waits.
    task automatic txn(input logic w, input logic [39:0] a, input logic [63:0] d,
                       output logic [63:0] rd, output logic er);
        int budget;
        rd = 'x; er = 'x;
        @(negedge clk);
        cmd_v = 1; cmd_w = w; cmd_addr = a; cmd_data = d;
        budget = 0;
        while (!cmd_ready && budget < 20) begin @(negedge clk); budget++; end
        if (!cmd_ready) begin
            check("accept_timeout", 64'(cmd_ready), 64'd1);
            cmd_v = 0;
            return;
        end
        @(posedge clk); #1;
        cmd_v = 0;
        budget = 0;
        while (!resp_v && budget < 20) begin @(posedge clk); #1; budget++; end
        if (!resp_v) begin
            check("resp_timeout", 64'(resp_v), 64'd1);
            return;
        end
        rd = resp_data; er = resp_err;
        check("ready_low_while_resp", 64'(cmd_ready), 64'd0);
        resp_yumi = 1;
        @(posedge clk); #1;
        resp_yumi = 0;
    endtask

    // DUT transaction compared against the model; returns DUT data.
    task automatic run_and_check(input logic w, input logic [39:0] a, input logic [63:0] d,
                                 output logic [63:0] rd, output logic er);
        logic [63:0] ed;
        logic        ee;
        txn(w, a, d, rd, er);
        model_step(w, a, d, ed, ee);
        $display("txn w=%0d addr=%h wdata=%h -> data=%h err=%0d active=%0d", w, a, d, rd, er, active);
        check($sformatf("model_data@%h", a), rd, ed);
        check($sformatf("model_err@%h", a), 64'(er), 64'(ee));
        check($sformatf("model_active@%h", a), 64'(active), 64'(model_active()));
    endtask

    function automatic void add_vec(input logic w, input logic [19:0] off, input logic [63:0] d,
                                    input logic [63:0] ed, input logic ee, input logic ea);
        vec_t v;
        v.w = w; v.addr = base_c | 40'(off); v.data = d;
        v.exp_data = ed; v.exp_err = ee; v.exp_active = ea;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [63:0] rd, held;
        logic        er;
        logic [19:0] off;
        logic [63:0] val;
        int          budget;

        model_reset();

        // Reset phase.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset_resp_v", 64'(resp_v), 64'd0);
        check("reset_resp_data", resp_data, 64'd0);
        check("reset_resp_err", 64'(resp_err), 64'd0);
        check("reset_active", 64'(active), 64'd0);
        reset = 0;

        // Directed table.
        add_vec(0, 20'h00, 0, 0, 0, 0);
        add_vec(1, 20'h08, 64'hDEAD_0000_0000_000A, 0, 0, 0);
        add_vec(1, 20'h10, 35, 0, 0, 0);
        add_vec(1, 20'h20, 10, 0, 0, 0);
        add_vec(1, 20'h00, 1, 0, 0, 1);
        add_vec(0, 20'h18, 0, 10, 0, 1);
        add_vec(0, 20'h18, 0, 20, 0, 1);
        add_vec(0, 20'h18, 0, 30, 0, 0);
        add_vec(0, 20'h18, 0, 35, 0, 0);
        add_vec(0, 20'h18, 0, 35, 0, 0);
        add_vec(0, 20'h00, 0, 3, 0, 0);
        add_vec(0, 20'h08, 0, 10, 0, 0);
        add_vec(1, 20'h20, 0, 0, 0, 0);
        add_vec(1, 20'h08, 5, 0, 0, 0);
        add_vec(1, 20'h10, 9, 0, 0, 0);
        add_vec(1, 20'h00, 1, 0, 0, 1);
        add_vec(0, 20'h18, 0, 5, 0, 1);
        add_vec(0, 20'h18, 0, 5, 0, 1);
        add_vec(0, 20'h00, 0, 1, 0, 1);
        add_vec(0, 20'h28, 0, 0, 1, 1);
        add_vec(0, 20'h0C, 0, 0, 1, 1);
        add_vec(1, 20'h28, 64'h77, 0, 1, 1);
        add_vec(1, 20'h0C, 64'h77, 0, 1, 1);
        add_vec(0, 20'h08, 0, 5, 0, 1);
        add_vec(0, 20'h10, 0, 9, 0, 1);
        add_vec(0, 20'h20, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            run_and_check(vecs[i].w, vecs[i].addr, vecs[i].data, rd, er);
            check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_active", i), 64'(active), 64'(vecs[i].exp_active));
        end

        // Saturation: cursor + size wraps 32 bits, must clamp to end.
        run_and_check(1, base_c | 40'h10, 64'hFFFF_FFFF, rd, er);
        run_and_check(1, base_c | 40'h20, 64'h20, rd, er);
        run_and_check(1, base_c | 40'h00, 64'h1, rd, er);
        run_and_check(1, base_c | 40'h18, 64'hFFFF_FFF0, rd, er);
        run_and_check(0, base_c | 40'h18, 0, rd, er);
        check("sat_claim", rd, 64'hFFFF_FFF0);
        run_and_check(0, base_c | 40'h18, 0, rd, er);
        check("sat_after_clamp", rd, 64'hFFFF_FFFF);
        check("sat_active", 64'(active), 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            int pick = $urandom_range(0, 15);
            val = {$urandom(), (($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 + $urandom_range(0, 255)
                                                           : 32'($urandom_range(0, 80)))};
            case (pick)
                0, 1:       off = 20'h00;
                2:          off = 20'h08;
                3:          off = 20'h10;
                4:          off = 20'h18;
                5:          off = 20'h20;
                6:          off = 20'($urandom_range(0, 20'hFFFFF));
                default:    off = 20'h18;
            endcase
            if (pick == 0) val[0] = 1'b1;
            run_and_check((pick <= 6) ? logic'($urandom_range(0, 1)) : 1'b0,
                          base_c | 40'(off), val, rd, er);
        end

        // Hold response unconsumed, then reset in the middle of the hold.
        run_and_check(1, base_c | 40'h08, 0, rd, er);
        run_and_check(1, base_c | 40'h10, 100, rd, er);
        run_and_check(1, base_c | 40'h20, 1, rd, er);
        run_and_check(1, base_c | 40'h00, 1, rd, er);
        @(negedge clk);
        cmd_v = 1; cmd_w = 0; cmd_addr = base_c | 40'h18;
        budget = 0;
        while (!cmd_ready && budget < 20) begin @(negedge clk); budget++; end
        @(posedge clk); #1;
        cmd_v = 0;
        held = resp_data;
        check("hold_first_data", held, 64'd0);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d_v", c), 64'(resp_v), 64'd1);
            check($sformatf("hold%0d_data", c), resp_data, held);
            check($sformatf("hold%0d_ready", c), 64'(cmd_ready), 64'd0);
            @(posedge clk); #1;
        end
        $display("hold: resp_v=%0d data=%h held 5 cycles", resp_v, resp_data);
        reset = 1;
        @(posedge clk); #1;
        check("midreset_resp_v", 64'(resp_v), 64'd0);
        check("midreset_resp_data", resp_data, 64'd0);
        check("midreset_ready", 64'(cmd_ready), 64'd0);
        check("midreset_active", 64'(active), 64'd0);
        @(negedge clk);
        reset = 0;
        model_reset();
        run_and_check(0, base_c | 40'h00, 0, rd, er);
        run_and_check(0, base_c | 40'h08, 0, rd, er);
        check("post_reset_start", rd, 64'd0);
        run_and_check(0, base_c | 40'h10, 0, rd, er);
        check("post_reset_end", rd, 64'd0);
        run_and_check(0, base_c | 40'h20, 0, rd, er);
        check("post_reset_size", rd, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
